// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller and the ID-stage decoder that feeds it.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    typedef enum logic [0:0] {
        StRun,
        StMdBusy
    } md_state_e;

    // Decoder helpers: derive muldiv_id / uses_hilo_id from opcode and funct.
    function automatic logic is_muldiv(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_SPECIAL) &&
               (funct == FUNCT_MULT || funct == FUNCT_MULTU ||
                funct == FUNCT_DIV  || funct == FUNCT_DIVU);
    endfunction

    function automatic logic is_hilo_read(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_SPECIAL) && (funct == FUNCT_MFHI || funct == FUNCT_MFLO);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use and mul/div interlocks, taken-branch
// flush, and a saturating stall-cycle counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic             uses_hilo_id,
    input  logic             muldiv_id,
    input  logic             MemRead_ex,
    input  logic             RegWrite_ex,
    input  logic [REG_W-1:0] WriteReg_ex,
    input  logic             muldiv_start_ex,
    input  logic             branch_taken_ex,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned MdCntW = $clog2(MD_LATENCY + 1);
    localparam logic [MdCntW-1:0] MdLoad = MdCntW'(MD_LATENCY);

    md_state_e         state_q, state_d;
    logic [MdCntW-1:0] md_cnt_q, md_cnt_d;

    logic load_haz;
    logic md_haz;
    logic stall;
    logic stall_count_en;

    // Register $0 is hardwired, so a load targeting it never creates a real dependency.
    assign load_haz = MemRead_ex && RegWrite_ex && (WriteReg_ex != REG_ZERO) &&
                      ((uses_rs_id && (rs_id == WriteReg_ex)) ||
                       (uses_rt_id && (rt_id == WriteReg_ex)));

    assign md_busy = (state_q == StMdBusy);
    assign md_haz  = md_busy && (uses_hilo_id || muldiv_id);
    assign stall   = load_haz || md_haz;

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            StRun: begin
                if (muldiv_start_ex) begin
                    state_d  = StMdBusy;
                    md_cnt_d = MdLoad;
                end
            end
            StMdBusy: begin
                if (muldiv_start_ex) begin
                    md_cnt_d = MdLoad;
                end else if (md_cnt_q == MdCntW'(1)) begin
                    state_d  = StRun;
                    md_cnt_d = '0;
                end else begin
                    md_cnt_d = md_cnt_q - MdCntW'(1);
                end
            end
            default: begin
                state_d  = StRun;
                md_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StRun;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // A taken branch overrides any stall: the ID instruction is wrong-path and gets squashed.
    always_comb begin
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        stall_count_en = 1'b0;
        if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_write       = 1'b0;
            ifid_write     = 1'b0;
            idex_bubble    = 1'b1;
            stall_count_en = 1'b1;
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_count_en),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed hazard scenarios followed by random traffic.
module tb_hazard_stall_ctrl;

    localparam int unsigned LAT = 8;
    localparam int unsigned CW  = 4;
    localparam int          SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs_id, rt_id, WriteReg_ex;
    logic          uses_rs_id, uses_rt_id, uses_hilo_id, muldiv_id;
    logic          MemRead_ex, RegWrite_ex, muldiv_start_ex, branch_taken_ex;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;
    logic [CW-1:0] stall_cycles;

    hazard_stall_ctrl #(
        .MD_LATENCY (LAT),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .uses_rs_id      (uses_rs_id),
        .uses_rt_id      (uses_rt_id),
        .uses_hilo_id    (uses_hilo_id),
        .muldiv_id       (muldiv_id),
        .MemRead_ex      (MemRead_ex),
        .RegWrite_ex     (RegWrite_ex),
        .WriteReg_ex     (WriteReg_ex),
        .muldiv_start_ex (muldiv_start_ex),
        .branch_taken_ex (branch_taken_ex),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc;
        logic       ifw;
        logic       ifl;
        logic       bub;
        logic       busy;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    event ev_issue;
    int   checks = 0;
    int   errors = 0;

    // Reference state: cycles the mul/div unit stays busy, and total stall cycles (saturated).
    int md_left   = 0;
    int stall_tot = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic cycle(input logic rstn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic hilo, input logic md,
                         input logic mr, input logic rw, input logic [4:0] wr,
                         input logic st, input logic br);
        exp_t e;
        bit   load, mdh, busy;
        @(negedge clk);
        rst_n = rstn; rs_id = rs; rt_id = rt; uses_rs_id = urs; uses_rt_id = urt;
        uses_hilo_id = hilo; muldiv_id = md; MemRead_ex = mr; RegWrite_ex = rw;
        WriteReg_ex = wr; muldiv_start_ex = st; branch_taken_ex = br;

        busy = (md_left > 0);
        load = mr && rw && (wr != 0) && ((urs && rs == wr) || (urt && rt == wr));
        mdh  = busy && (hilo || md);
        e.busy = busy;
        e.cnt  = 8'(stall_tot);
        if (br)               {e.pc, e.ifw, e.ifl, e.bub} = 4'b1111;
        else if (load || mdh) {e.pc, e.ifw, e.ifl, e.bub} = 4'b0001;
        else                  {e.pc, e.ifw, e.ifl, e.bub} = 4'b1100;
        q.push_back(e);
        -> ev_issue;

        // Advance the model across the coming rising edge.
        if (!rstn) begin
            md_left   = 0;
            stall_tot = 0;
        end else begin
            if (!br && (load || mdh) && stall_tot < SAT) stall_tot++;
            if (st) md_left = LAT;
            else if (md_left > 0) md_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Issue a mul/div, then keep an mflo in ID for `hold` cycles.
    task automatic muldiv_then_mflo(input int hold);
        cycle(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < hold; i++) cycle(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(ev_issue);
            #1;
            if (q.size() == 0) begin
                check("queue_underflow", 1, 0);
            end else begin
                e = q.pop_front();
                check("pc_write", int'(pc_write), int'(e.pc));
                check("ifid_write", int'(ifid_write), int'(e.ifw));
                check("ifid_flush", int'(ifid_flush), int'(e.ifl));
                check("idex_bubble", int'(idex_bubble), int'(e.bub));
                check("md_busy", int'(md_busy), int'(e.busy));
                check("stall_cycles", int'(stall_cycles), int'(e.cnt));
            end
        end
    end

    initial begin : driver
        rst_n = 0; rs_id = 0; rt_id = 0; uses_rs_id = 0; uses_rt_id = 0; uses_hilo_id = 0;
        muldiv_id = 0; MemRead_ex = 0; RegWrite_ex = 0; WriteReg_ex = 0;
        muldiv_start_ex = 0; branch_taken_ex = 0;
        repeat (2) @(posedge clk);

        idle(2);
        // Load-use on rs, then on rt
        cycle(1, 5, 0, 1, 0, 0, 0, 1, 1, 5, 0, 0);
        idle(1);
        cycle(1, 1, 9, 1, 1, 0, 0, 1, 1, 9, 0, 0);
        // Load to $0, and matching rt that is unused
        cycle(1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        cycle(1, 3, 7, 1, 0, 0, 0, 1, 1, 7, 0, 0);
        // Matching register but not a load
        cycle(1, 6, 0, 1, 0, 0, 0, 0, 1, 6, 0, 0);
        // Mul/div with mflo waiting, released on the 9th cycle
        muldiv_then_mflo(10);
        idle(1);
        // Branch while a load-use hazard is present
        cycle(1, 4, 0, 1, 0, 0, 0, 1, 1, 4, 0, 1);
        // Branch during mul/div does not disturb the unit
        cycle(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        idle(8);
        // Reset mid mul/div
        muldiv_then_mflo(3);
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Saturation of the 4-bit counter
        muldiv_then_mflo(9);
        muldiv_then_mflo(9);
        muldiv_then_mflo(9);
        idle(1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)),
                  (md_left == 0) ? 1'($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 40) == 0),
                  1'($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall and flush controller for the 5-stage MIPS pipeline. It covers the hazards that bypassing cannot resolve.
- Detects load-use hazards between the ID and EX stages.
- Tracks the multi-cycle mul/div unit with a busy state machine and down-counter.
- Redirects and flushes on a taken branch resolved in EX.
- Drives PC, IF/ID and ID/EX write/bubble controls. Keeps a saturating stall-cycle performance counter.

Parameters:
- MD_LATENCY, 8, number of cycles after mul/div issue before HI/LO is valid (legal range ≥1).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- rs_id  input  5  rs field of the instruction in ID
- rt_id  input  5  rt field of the instruction in ID
- uses_rs_id  input  1  ID instruction reads rs
- uses_rt_id  input  1  ID instruction reads rt
- uses_hilo_id  input  1  ID instruction is mfhi or mflo
- muldiv_id  input  1  ID instruction is mult, multu, div or divu
- MemRead_ex  input  1  EX instruction is a load
- RegWrite_ex  input  1  EX instruction writes the register file
- WriteReg_ex  input  5  destination register of the EX instruction
- muldiv_start_ex  input  1  mul/div in EX issues to the unit this cycle
- branch_taken_ex  input  1  branch/jump resolved taken in EX
- pc_write  output  1  PC register enable
- ifid_write  output  1  IF/ID register enable
- ifid_flush  output  1  clear IF/ID to a NOP
- idex_bubble  output  1  load a NOP into ID/EX
- md_busy  output  1  mul/div unit in progress
- stall_cycles  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n=0 at a rising edge): state=RUN, md_cnt=0, stall_cycles=0. Reset wins over every other input, including mid-mul/div.
- Combinational outputs right after reset, with idle inputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, md_busy=0.
- Load-use condition, load_haz:
  - MemRead_ex & RegWrite_ex & (WriteReg_ex≠0), and
  - ((uses_rs_id & rs_id==WriteReg_ex) | (uses_rt_id & rt_id==WriteReg_ex)).
- Mul/div hazard, md_haz: md_busy & (uses_hilo_id | muldiv_id).
- stall = load_haz | md_haz.
- State machine:
  - RUN: on a rising edge with muldiv_start_ex=1, set md_cnt=MD_LATENCY and go to MD_BUSY.
  - MD_BUSY: md_cnt decrements each edge. When md_cnt==1 at an edge, go to RUN with md_cnt=0.
  - md_busy = (state==MD_BUSY). It is high for exactly MD_LATENCY cycles after the issue cycle.
  - muldiv_start_ex while in MD_BUSY (prevented upstream by md_haz): reload md_cnt=MD_LATENCY and stay in MD_BUSY.
- Output priority, evaluated combinationally every cycle:
  1. branch_taken_ex=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. Any stall is ignored because the ID instruction is wrong-path. The mul/div state is unaffected, since the unit keeps running.
  2. Otherwise, if stall=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
  3. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Load-use stalls last 1 cycle. On the next cycle the load is in MEM, so the hazard clears and forwarding covers the dependency.
- Mul/div stalls persist while md_busy. ID is released in the cycle in which state returns to RUN.
- stall_cycles: +1 at each edge where case 2 applied. It saturates at all-ones and does not wrap. Flush cycles do not count.
- WriteReg_ex==0 never causes a stall.

Decomposition:
- Shared pipeline package:
  - REG_W=5 and the register-0 constant.
  - Opcode/funct constants for MULT, MULTU, DIV, DIVU, MFHI, MFLO, used by the decoder that generates uses_hilo_id and muldiv_id.
  - A two-value state enum: RUN and MD_BUSY.
- One natural sub-module: sat_counter (parameterised width, synchronous active-low clear, increment enable, saturate). It implements stall_cycles.
- Everything else stays flat.

Test Plan:
- Load-use on rs: MemRead_ex=1, RegWrite_ex=1, WriteReg_ex=5, rs_id=5, uses_rs_id=1 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for that cycle; stall_cycles 0→1.
- Load targets $0, or the matching source is unused: WriteReg_ex=0 with rs_id=0, or uses_rt_id=0 with rt_id=WriteReg_ex -> no stall; all outputs at idle values.
- Mul/div (MD_LATENCY=8): muldiv_start_ex pulses at cycle T, then mflo held in ID -> md_busy=1 for cycles T+1..T+8; stall held for those 8 cycles; released at T+9; stall_cycles=8.
- Branch during load-use: load_haz=1 and branch_taken_ex=1 together -> pc_write=1, ifid_flush=1, idex_bubble=1; stall_cycles unchanged.
- Reset mid-mul/div: rst_n=0 at T+3 of an 8-cycle op -> next cycle md_busy=0, stall_cycles=0, outputs at idle values.
- Saturation (CNT_W=4): hold md_haz for 20 cycles -> stall_cycles stops at 15.
